// File: rtl/zdbg_uart_cmd_rx_pkg.sv
// Shared types and constants for the debug-UART command receiver.
// Frame checksum support is selected by ZDBG_RX_CHECKSUM_EN.
package zdbg_uart_cmd_rx_pkg;

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned OP_W   = 3;
   localparam int unsigned EBR_AW = 10;
   localparam int unsigned EBR_DW = 16;

   localparam logic [BYTE_W-1:0] HDR0   = 8'h55;
   localparam logic [BYTE_W-1:0] HDR1   = 8'hAA;
   localparam logic [BYTE_W-1:0] CMD_WR = 8'h01;
   localparam logic [BYTE_W-1:0] CMD_OP = 8'h02;

   typedef enum logic [3:0] {
      PS_HUNT0,
      PS_HUNT1,
      PS_CMD,
      PS_P0,
      PS_P1,
      PS_P2,
      PS_P3,
      PS_CHK,
      PS_EXEC
   } parse_state_e;

endpackage

// File: rtl/zuart_rx_byte.sv
// 8N1 byte receiver: RxD synchroniser, mid-bit sampling and stop-bit check.
module zuart_rx_byte
   import zdbg_uart_cmd_rx_pkg::*;
#(
   parameter int unsigned Freq_divider = 24
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              rx_i,
   output logic [BYTE_W-1:0] byte_o,
   output logic              byte_vld_o,
   output logic              stop_err_o
);

   localparam int unsigned CNT_W = $clog2(Freq_divider);

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

   rx_state_e         state_q;
   logic [1:0]        sync_q;
   logic              prev_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [2:0]        bit_q;
   logic [BYTE_W-1:0] shift_q;
   logic              rxs;
   logic              fall;

   assign rxs  = sync_q[1];
   assign fall = prev_q & ~rxs;

   // Counter reloads put every sample in the middle of its bit cell.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q     <= 2'b11;
         prev_q     <= 1'b1;
         state_q    <= RX_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         byte_o     <= '0;
         byte_vld_o <= 1'b0;
         stop_err_o <= 1'b0;
      end else begin
         sync_q     <= {sync_q[0], rx_i};
         prev_q     <= rxs;
         byte_vld_o <= 1'b0;
         stop_err_o <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (fall) begin
                  state_q <= RX_START;
                  cnt_q   <= CNT_W'(Freq_divider / 2 - 1);
               end
            end
            RX_START: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else if (!rxs) begin
                  state_q <= RX_DATA;
                  cnt_q   <= CNT_W'(Freq_divider - 1);
                  bit_q   <= '0;
               end else begin
                  state_q <= RX_IDLE;
               end
            end
            RX_DATA: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  shift_q <= {rxs, shift_q[BYTE_W-1:1]};
                  cnt_q   <= CNT_W'(Freq_divider - 1);
                  if (bit_q == 3'd7) begin
                     state_q <= RX_STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end
            end
            RX_STOP: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end else begin
                  state_q <= RX_IDLE;
                  if (rxs) begin
                     byte_o     <= shift_q;
                     byte_vld_o <= 1'b1;
                  end else begin
                     stop_err_o <= 1'b1;
                  end
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/zdbg_uart_cmd_rx.sv
// Debug-UART command receiver: parses 55 AA CMD P0..P3 [CHK] frames into EBR
// writes or op requests. ZDBG_RX_CHECKSUM_EN adds and verifies the CHK byte.
module zdbg_uart_cmd_rx
   import zdbg_uart_cmd_rx_pkg::*;
#(
   parameter int unsigned Freq_divider   = 24,
   parameter int unsigned Timeout_Cycles = 4800
) (
   input  logic              iClk,
   input  logic              iRst_N,
   input  logic              iDbgUART_RxD,
   output logic              oEBR_Wr_En,
   output logic [EBR_AW-1:0] oEBR_Wr_Addr,
   output logic [EBR_DW-1:0] oEBR_Wr_Data,
   output logic [OP_W-1:0]   oOp_Code,
   input  logic              iOp_Done,
   output logic              oRx_Err
);

   localparam int unsigned TMO_W = $clog2(Timeout_Cycles);

   logic [BYTE_W-1:0] rx_byte;
   logic              rx_vld;
   logic              rx_stop_err;

   zuart_rx_byte #(.Freq_divider(Freq_divider)) u_rx_byte (
      .clk_i      (iClk),
      .rst_ni     (iRst_N),
      .rx_i       (iDbgUART_RxD),
      .byte_o     (rx_byte),
      .byte_vld_o (rx_vld),
      .stop_err_o (rx_stop_err)
   );

   parse_state_e      state_q;
   logic [BYTE_W-1:0] cmd_q;
   logic [1:0]        p0_q;
   logic [BYTE_W-1:0] p1_q;
   logic [BYTE_W-1:0] p2_q;
`ifdef ZDBG_RX_CHECKSUM_EN
   logic [BYTE_W-1:0] p3_q;
   logic [BYTE_W-1:0] chk_q;
`endif
   logic [TMO_W-1:0]  tmo_q;

   logic [BYTE_W-1:0] last_p3;
   logic              chk_ok;
   logic              exec_hit;
   logic              tmo_run;
   logic              tmo_hit;
   logic              op_busy;

   // The frame's final byte triggers execution; P3 comes from the wire when it is last.
   always_comb begin
`ifdef ZDBG_RX_CHECKSUM_EN
      last_p3  = p3_q;
      chk_ok   = (chk_q == rx_byte);
      exec_hit = rx_vld && (state_q == PS_CHK);
`else
      last_p3  = rx_byte;
      chk_ok   = 1'b1;
      exec_hit = rx_vld && (state_q == PS_P3);
`endif
      tmo_run = (state_q == PS_CMD) || (state_q == PS_P0) || (state_q == PS_P1) ||
                (state_q == PS_P2)  || (state_q == PS_P3) || (state_q == PS_CHK);
      tmo_hit = tmo_run && (tmo_q == TMO_W'(Timeout_Cycles - 1));
      op_busy = (oOp_Code != '0);
   end

   always_ff @(posedge iClk) begin
      if (!iRst_N) begin
         state_q      <= PS_HUNT0;
         cmd_q        <= '0;
         p0_q         <= '0;
         p1_q         <= '0;
         p2_q         <= '0;
`ifdef ZDBG_RX_CHECKSUM_EN
         p3_q         <= '0;
         chk_q        <= '0;
`endif
         tmo_q        <= '0;
         oEBR_Wr_En   <= 1'b0;
         oEBR_Wr_Addr <= '0;
         oEBR_Wr_Data <= '0;
         oOp_Code     <= '0;
         oRx_Err      <= 1'b0;
      end else begin
         oEBR_Wr_En <= 1'b0;
         oRx_Err    <= 1'b0;
         tmo_q      <= (tmo_run && !rx_vld) ? tmo_q + TMO_W'(1) : '0;

         // Done clears first; a pending op (old value) blocks any new load.
         if (op_busy && iOp_Done) begin
            oOp_Code <= '0;
         end

         if (rx_stop_err) begin
            oRx_Err <= 1'b1;
            state_q <= PS_HUNT0;
         end else if (exec_hit) begin
            state_q <= PS_EXEC;
            if (!chk_ok) begin
               oRx_Err <= 1'b1;
            end else if (cmd_q == CMD_WR) begin
               oEBR_Wr_En   <= 1'b1;
               oEBR_Wr_Addr <= {p0_q, p1_q};
               oEBR_Wr_Data <= {p2_q, last_p3};
            end else if (cmd_q == CMD_OP) begin
               if (op_busy) begin
                  oRx_Err <= 1'b1;
               end else begin
                  oOp_Code <= last_p3[OP_W-1:0];
               end
            end else begin
               oRx_Err <= 1'b1;
            end
         end else if (tmo_hit && !rx_vld) begin
            state_q <= PS_HUNT0;
         end else begin
            case (state_q)
               PS_HUNT0: if (rx_vld && rx_byte == HDR0) state_q <= PS_HUNT1;
               PS_HUNT1: begin
                  if (rx_vld) begin
                     if (rx_byte == HDR1)      state_q <= PS_CMD;
                     else if (rx_byte != HDR0) state_q <= PS_HUNT0;
                  end
               end
               PS_CMD: begin
                  if (rx_vld) begin
                     cmd_q   <= rx_byte;
`ifdef ZDBG_RX_CHECKSUM_EN
                     chk_q   <= rx_byte;
`endif
                     state_q <= PS_P0;
                  end
               end
               PS_P0: begin
                  if (rx_vld) begin
                     p0_q    <= rx_byte[1:0];
`ifdef ZDBG_RX_CHECKSUM_EN
                     chk_q   <= chk_q ^ rx_byte;
`endif
                     state_q <= PS_P1;
                  end
               end
               PS_P1: begin
                  if (rx_vld) begin
                     p1_q    <= rx_byte;
`ifdef ZDBG_RX_CHECKSUM_EN
                     chk_q   <= chk_q ^ rx_byte;
`endif
                     state_q <= PS_P2;
                  end
               end
               PS_P2: begin
                  if (rx_vld) begin
                     p2_q    <= rx_byte;
`ifdef ZDBG_RX_CHECKSUM_EN
                     chk_q   <= chk_q ^ rx_byte;
`endif
                     state_q <= PS_P3;
                  end
               end
`ifdef ZDBG_RX_CHECKSUM_EN
               PS_P3: begin
                  if (rx_vld) begin
                     p3_q    <= rx_byte;
                     chk_q   <= chk_q ^ rx_byte;
                     state_q <= PS_CHK;
                  end
               end
               PS_CHK:  ;
`else
               PS_P3:   ;
`endif
               default: state_q <= PS_HUNT0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_zdbg_uart_cmd_rx.sv
// Directed bench for zdbg_uart_cmd_rx: vector table of frames plus hand-built
// sequences for op handshake, stop error, timeout, glitch and mid-frame reset.
module tb_zdbg_uart_cmd_rx;

   localparam int BIT = 24;
`ifdef ZDBG_RX_CHECKSUM_EN
   localparam bit CHK_ON = 1'b1;
`else
   localparam bit CHK_ON = 1'b0;
`endif

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b0;
   logic        rxd     = 1'b1;
   logic        op_done = 1'b0;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [15:0] wr_data;
   logic [2:0]  op_code;
   logic        rx_err;

   int checks = 0;
   int errors = 0;
   int wr_cnt = 0;
   int err_cnt = 0;
   logic [9:0]  cap_addr = '0;
   logic [15:0] cap_data = '0;

   always #5 clk = ~clk;

   zdbg_uart_cmd_rx dut (
      .iClk         (clk),
      .iRst_N       (rst_n),
      .iDbgUART_RxD (rxd),
      .oEBR_Wr_En   (wr_en),
      .oEBR_Wr_Addr (wr_addr),
      .oEBR_Wr_Data (wr_data),
      .oOp_Code     (op_code),
      .iOp_Done     (op_done),
      .oRx_Err      (rx_err)
   );

   always @(negedge clk) begin
      if (wr_en) begin
         wr_cnt++;
         cap_addr = wr_addr;
         cap_data = wr_data;
      end
      if (rx_err) err_cnt++;
   end

   typedef struct {
      logic [7:0]  cmd, p0, p1, p2, p3;
      logic        bad;
      logic        exp_wr;
      logic [9:0]  addr;
      logic [15:0] data;
      logic        exp_err;
      logic [2:0]  op;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         repeat (BIT) @(negedge clk);
      end
      rxd = stop;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3, input logic bad);
      logic [7:0] chk;
      chk = cmd ^ p0 ^ p1 ^ p2 ^ p3 ^ (bad ? 8'hFF : 8'h00);
      send_byte(8'h55, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(cmd, 1'b1);
      send_byte(p0, 1'b1);
      send_byte(p1, 1'b1);
      send_byte(p2, 1'b1);
      send_byte(p3, 1'b1);
      if (CHK_ON) send_byte(chk, 1'b1);
      repeat (20) @(negedge clk);
   endtask

   int w0, e0;
   logic ew, ee;

   initial begin
      vecs[0] = '{8'h01, 8'h02, 8'h34, 8'hBE, 8'hEF, 1'b0, 1'b1, 10'h234, 16'hBEEF, 1'b0, 3'd0};
      vecs[1] = '{8'h01, 8'hFF, 8'h00, 8'h12, 8'h34, 1'b0, 1'b1, 10'h300, 16'h1234, 1'b0, 3'd0};
      vecs[2] = '{8'h01, 8'h03, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1, 10'h3FF, 16'hFFFF, 1'b0, 3'd0};
      vecs[3] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 10'h000, 16'h0000, 1'b0, 3'd0};
      vecs[4] = '{8'h07, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 3'd0};
      vecs[5] = '{8'h01, 8'h01, 8'h23, 8'h45, 8'h67, 1'b1, 1'b1, 10'h123, 16'h4567, 1'b0, 3'd0};
      vecs[6] = '{8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hF8, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b0, 3'd0};
      vecs[7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 10'h000, 16'h0000, 1'b1, 3'd0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst wr_en", 32'(wr_en), 32'd0);
      check("rst addr", 32'(wr_addr), 32'd0);
      check("rst data", 32'(wr_data), 32'd0);
      check("rst op", 32'(op_code), 32'd0);
      check("rst err", 32'(rx_err), 32'd0);
      rst_n = 1'b1;
      repeat (2 * BIT) @(negedge clk);

      // Frame table, sent back to back
      for (int i = 0; i < 8; i++) begin
         w0 = wr_cnt;
         e0 = err_cnt;
         send_frame(vecs[i].cmd, vecs[i].p0, vecs[i].p1, vecs[i].p2, vecs[i].p3, vecs[i].bad);
         ew = vecs[i].exp_wr;
         ee = vecs[i].exp_err;
         if (vecs[i].bad && CHK_ON) begin
            ew = 1'b0;
            ee = 1'b1;
         end
         check($sformatf("vec%0d wr_cnt", i), 32'(wr_cnt - w0), 32'(ew));
         check($sformatf("vec%0d err_cnt", i), 32'(err_cnt - e0), 32'(ee));
         check($sformatf("vec%0d op", i), 32'(op_code), 32'(vecs[i].op));
         if (ew) begin
            check($sformatf("vec%0d addr", i), 32'(cap_addr), 32'(vecs[i].addr));
            check($sformatf("vec%0d data", i), 32'(cap_data), 32'(vecs[i].data));
         end
      end

      // Op request, pending rejection, write while pending, done handshake
      e0 = err_cnt;
      send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 1'b0);
      check("op load", 32'(op_code), 32'd3);
      check("op load err", 32'(err_cnt - e0), 32'd0);
      repeat (100) @(negedge clk);
      check("op hold", 32'(op_code), 32'd3);
      e0 = err_cnt;
      send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h05, 1'b0);
      check("op pending err", 32'(err_cnt - e0), 32'd1);
      check("op pending keep", 32'(op_code), 32'd3);
      w0 = wr_cnt;
      send_frame(8'h01, 8'h01, 8'hAB, 8'hCD, 8'hEF, 1'b0);
      check("wr while op wr_cnt", 32'(wr_cnt - w0), 32'd1);
      check("wr while op addr", 32'(cap_addr), 32'h1AB);
      check("wr while op data", 32'(cap_data), 32'hCDEF);
      op_done = 1'b1;
      check("op before done edge", 32'(op_code), 32'd3);
      @(negedge clk);
      op_done = 1'b0;
      check("op cleared", 32'(op_code), 32'd0);

      // Stop-bit error followed by a valid frame
      w0 = wr_cnt;
      e0 = err_cnt;
      send_byte(8'h55, 1'b0);
      repeat (2 * BIT) @(negedge clk);
      send_frame(8'h01, 8'h00, 8'h77, 8'h12, 8'h34, 1'b0);
      check("stoperr err_cnt", 32'(err_cnt - e0), 32'd1);
      check("stoperr wr_cnt", 32'(wr_cnt - w0), 32'd1);
      check("stoperr addr", 32'(cap_addr), 32'h077);
      check("stoperr data", 32'(cap_data), 32'h1234);

      // Inter-byte timeout drops a stale partial frame
      w0 = wr_cnt;
      e0 = err_cnt;
      send_byte(8'h55, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h01, 1'b1);
      repeat (5000) @(negedge clk);
      send_frame(8'h01, 8'h02, 8'h34, 8'hBE, 8'hEF, 1'b0);
      check("timeout wr_cnt", 32'(wr_cnt - w0), 32'd1);
      check("timeout err_cnt", 32'(err_cnt - e0), 32'd0);
      check("timeout addr", 32'(cap_addr), 32'h234);
      check("timeout data", 32'(cap_data), 32'hBEEF);

      // Short low glitch, then a frame with a repeated 0x55 header byte
      w0 = wr_cnt;
      e0 = err_cnt;
      rxd = 1'b0;
      repeat (10) @(negedge clk);
      rxd = 1'b1;
      repeat (400) @(negedge clk);
      check("glitch wr_cnt", 32'(wr_cnt - w0), 32'd0);
      check("glitch err_cnt", 32'(err_cnt - e0), 32'd0);
      send_byte(8'h55, 1'b1);
      send_frame(8'h01, 8'h02, 8'h5A, 8'hC3, 8'h3C, 1'b0);
      check("hunt1 wr_cnt", 32'(wr_cnt - w0), 32'd1);
      check("hunt1 addr", 32'(cap_addr), 32'h25A);
      check("hunt1 data", 32'(cap_data), 32'hC33C);

      // Reset in the middle of P1
      w0 = wr_cnt;
      e0 = err_cnt;
      send_byte(8'h55, 1'b1);
      send_byte(8'hAA, 1'b1);
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      rxd = 1'b0;
      repeat (BIT) @(negedge clk);
      rxd = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst addr", 32'(wr_addr), 32'd0);
      check("midrst data", 32'(wr_data), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      check("midrst no wr", 32'(wr_cnt - w0), 32'd0);
      check("midrst no err", 32'(err_cnt - e0), 32'd0);
      send_frame(8'h01, 8'h01, 8'h11, 8'h22, 8'h33, 1'b0);
      check("postrst wr_cnt", 32'(wr_cnt - w0), 32'd1);
      check("postrst addr", 32'(cap_addr), 32'h111);
      check("postrst data", 32'(cap_data), 32'h2233);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
